ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
Parametrised, clocked return-address stack for the core's call/return path. It supersedes the unclocked 18-bit push/pop stack. It adds configurable width and depth, full/empty/count status, and a simultaneous push+pop (replace-top) operation. It also adds a selectable overflow policy (reject or wrap), sticky error flags and a synchronous flush. It sits between the PC unit (CALL pushes the return PC, RET pops it) and the next-PC mux.

Parameters:
WIDTH, 18, bit width of each stored PC.
DEPTH, 8, number of entries; power of two, >= 2.
WRAP_MODE, 0, 0 = push when full is rejected; 1 = push when full overwrites the oldest entry.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
push  input  1  store read_PC as new top at this edge.
pop  input  1  remove top at this edge.
flush  input  1  synchronous clear of all entries.
clear_err  input  1  synchronous clear of the sticky error flags.
read_PC  input  WIDTH  value to push.
write_PC  output  WIDTH  current top entry; 0 when empty.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
count  output  $clog2(DEPTH+1)  number of valid entries.
overflow  output  1  sticky: a push arrived while full without pop.
underflow  output  1  sticky: a pop arrived while empty without push.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, top pointer=0, overflow=0, underflow=0. Outputs: write_PC=0, empty=1, full=0. Storage contents are don't-care.
- Storage: circular array of DEPTH entries, with a top pointer (log2 DEPTH bits, wraps modulo DEPTH) and a count.
- write_PC is combinational from the registered top entry and count. After an edge that changes the top, the new value appears in the same cycle. Pop latency is zero: the value popped at edge N is the write_PC visible in the cycle before edge N.
- Per-edge priority: flush > {push, pop}. clear_err is independent.
- flush=1: count<=0, pointer<=0. Flags are unchanged unless clear_err=1. Push and pop are ignored.
- push only, not full: pointer<=pointer+1, entry[pointer+1]<=read_PC, count+1.
- push only, full, WRAP_MODE=0: no state change; overflow<=1.
- push only, full, WRAP_MODE=1: pointer advances and writes as normal, overwriting the oldest entry; count stays DEPTH; overflow<=1.
- pop only, not empty: pointer<=pointer-1, count-1. Entry contents are not cleared.
- pop only, empty: no state change; underflow<=1.
- push+pop, not empty: entry[pointer]<=read_PC (replace top); pointer and count unchanged; no flag set, including when full.
- push+pop, empty: behaves as push only; no underflow.
- clear_err=1: overflow<=0, underflow<=0. If an error event occurs in the same cycle, the set wins.
- Neither push nor pop: hold all state.
- Reset asserted mid-sequence clears everything immediately. The first push after rst_n deasserts lands at count=1.
- count never exceeds DEPTH and never goes negative. Pointer arithmetic is modulo DEPTH with no out-of-range index.

Test Plan:
1. DEPTH=8, WRAP_MODE=0. Push 5 values (0x00001, 0x1ABCD, 0x3FFFF, 0x20000, 0x00F0F), then 5 pops. Required: write_PC reads 0x00F0F, 0x20000, 0x3FFFF, 0x1ABCD, 0x00001 before each pop; empty=1 and write_PC=0 at the end; underflow=0.
2. Pop on empty. Required: underflow=1, count stays 0. Then assert clear_err for 1 cycle. Required: underflow=0.
3. WRAP_MODE=0. Push 9 values 1..9. Required: full=1, count=8, overflow=1, write_PC=8. Then pop 8 times. Required: sequence 8..1, then empty=1.
4. WRAP_MODE=1. Push 1..10. Required: count=8, overflow=1, write_PC=10. Pop 8 times. Required: sequence 10..3, then empty=1.
5. Push 0x11111 and 0x22222, then push+pop with read_PC=0x33333. Required: count=2, write_PC=0x33333; a following pop exposes 0x11111. Also: push+pop on empty with read_PC=0x0AAAA gives count=1, write_PC=0x0AAAA, underflow=0.
6. Push 3 values, then flush. Required: count=0, empty=1, write_PC=0 next cycle. Then push 3 values, drive rst_n low mid-cycle. Required: count=0 and write_PC=0 without waiting for a clk edge.

Source files
------------

// File: rtl/ret_addr_stack.sv
// Return-address stack for the call/return path: circular storage with a top
// pointer, replace-top on simultaneous push+pop, sticky error flags and flush.
module ret_addr_stack #(
   parameter int WIDTH     = 18,
   parameter int DEPTH     = 8,
   parameter int WRAP_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic                       clear_err,
   input  logic [WIDTH-1:0]           read_PC,
   output logic [WIDTH-1:0]           write_PC,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_next;
   logic [CW-1:0]    cnt;
   logic             is_empty;
   logic             is_full;
   logic             wrap_en;
   logic             op_push;
   logic             op_pop;
   logic             op_replace;
   logic             ovf_evt;
   logic             udf_evt;

   assign wrap_en  = (WRAP_MODE != 0);
   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == CNT_MAX);
   assign ptr_next = ptr + PW'(1);

   // Operation decode; push+pop on an empty stack degrades to a plain push.
   always_comb begin
      op_push    = 1'b0;
      op_pop     = 1'b0;
      op_replace = 1'b0;
      ovf_evt    = 1'b0;
      udf_evt    = 1'b0;
      if (!flush) begin
         if (push && pop && !is_empty) begin
            op_replace = 1'b1;
         end else if (push) begin
            op_push = !is_full || wrap_en;
            ovf_evt = is_full;
         end else if (pop) begin
            op_pop  = !is_empty;
            udf_evt = is_empty;
         end
      end
   end

   // Storage holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (op_push) begin
         mem[ptr_next] <= read_PC;
      end else if (op_replace) begin
         mem[ptr] <= read_PC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
      end else if (flush) begin
         ptr <= '0;
         cnt <= '0;
      end else if (op_push) begin
         ptr <= ptr_next;
         if (!is_full) begin
            cnt <= cnt + CW'(1);
         end
      end else if (op_pop) begin
         ptr <= ptr - PW'(1);
         cnt <= cnt - CW'(1);
      end
   end

   // Sticky flags: a same-edge error event outranks clear_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (clear_err) begin
            overflow <= 1'b0;
         end
         if (udf_evt) begin
            underflow <= 1'b1;
         end else if (clear_err) begin
            underflow <= 1'b0;
         end
      end
   end

   assign write_PC = is_empty ? '0 : mem[ptr];
   assign empty    = is_empty;
   assign full     = is_full;
   assign count    = cnt;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: reject and wrap instances share stimulus and are
// compared every cycle against queue models, plus literal directed checks.
module tb_ret_addr_stack;

   localparam int WIDTH = 18;
   localparam int DEPTH = 8;
   typedef logic [WIDTH-1:0] pc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic push = 1'b0, pop = 1'b0, flush = 1'b0, clear_err = 1'b0;
   pc_t  read_pc = '0;

   pc_t        top0, top1;
   logic       emp0, emp1, ful0, ful1, ovf0, ovf1, udf0, udf1;
   logic [3:0] cnt0, cnt1;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   pc_t q0[$];
   pc_t q1[$];
   bit  m_ovf0, m_udf0, m_ovf1, m_udf1;

   always #5 clk = ~clk;

   ret_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
      .clear_err(clear_err), .read_PC(read_pc), .write_PC(top0), .empty(emp0),
      .full(ful0), .count(cnt0), .overflow(ovf0), .underflow(udf0));

   ret_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
      .clear_err(clear_err), .read_PC(read_pc), .write_PC(top1), .empty(emp1),
      .full(ful1), .count(cnt1), .overflow(ovf1), .underflow(udf1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stack model: a queue whose back is the top; wrap drops the front.
   task automatic model_step(input bit wrap, inout pc_t q[$], inout bit ovf, inout bit udf);
      bit ovf_set = 1'b0;
      bit udf_set = 1'b0;
      if (flush) begin
         q.delete();
      end else if (push && pop && q.size() > 0) begin
         q[q.size()-1] = read_pc;
      end else if (push) begin
         if (q.size() < DEPTH) begin
            q.push_back(read_pc);
         end else begin
            ovf_set = 1'b1;
            if (wrap) begin
               void'(q.pop_front());
               q.push_back(read_pc);
            end
         end
      end else if (pop) begin
         if (q.size() > 0) void'(q.pop_back());
         else udf_set = 1'b1;
      end
      if (clear_err) begin
         ovf = 1'b0;
         udf = 1'b0;
      end
      if (ovf_set) ovf = 1'b1;
      if (udf_set) udf = 1'b1;
   endtask

   function automatic pc_t top_of(input pc_t q[$]);
      return (q.size() == 0) ? pc_t'(0) : q[q.size()-1];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         m_ovf0 = 1'b0; m_udf0 = 1'b0;
         m_ovf1 = 1'b0; m_udf1 = 1'b0;
      end else begin
         model_step(1'b0, q0, m_ovf0, m_udf0);
         model_step(1'b1, q1, m_ovf1, m_udf1);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m0_top", 32'(top0), 32'(top_of(q0)));
         check("m0_cnt", 32'(cnt0), 32'(q0.size()));
         check("m0_empty", 32'(emp0), 32'(q0.size() == 0));
         check("m0_full", 32'(ful0), 32'(q0.size() == DEPTH));
         check("m0_ovf", 32'(ovf0), 32'(m_ovf0));
         check("m0_udf", 32'(udf0), 32'(m_udf0));
         check("m1_top", 32'(top1), 32'(top_of(q1)));
         check("m1_cnt", 32'(cnt1), 32'(q1.size()));
         check("m1_empty", 32'(emp1), 32'(q1.size() == 0));
         check("m1_full", 32'(ful1), 32'(q1.size() == DEPTH));
         check("m1_ovf", 32'(ovf1), 32'(m_ovf1));
         check("m1_udf", 32'(udf1), 32'(m_udf1));
      end
   end

   // Apply one set of inputs across one rising edge; returns 2ns after it.
   task automatic cyc(input bit p, input bit po, input bit f, input bit ce, input pc_t v);
      push = p; pop = po; flush = f; clear_err = ce; read_pc = v;
      @(posedge clk);
      #2;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; read_pc = '0;
   endtask

   pc_t t1_vals [5];

   initial begin
      t1_vals[0] = 18'h00001; t1_vals[1] = 18'h1ABCD; t1_vals[2] = 18'h3FFFF;
      t1_vals[3] = 18'h20000; t1_vals[4] = 18'h00F0F;

      repeat (2) @(posedge clk);
      #2;
      check("rst_cnt", 32'(cnt0), 0);
      check("rst_top", 32'(top0), 0);
      check("rst_empty", 32'(emp0), 1);
      check("rst_full", 32'(ful0), 0);
      check("rst_ovf", 32'(ovf1), 0);
      check("rst_udf", 32'(udf1), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #2;

      // T1: LIFO order
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, t1_vals[i]);
      for (int i = 4; i >= 0; i--) begin
         check("t1_top", 32'(top0), 32'(t1_vals[i]));
         cyc(0, 1, 0, 0, '0);
      end
      check("t1_empty", 32'(emp0), 1);
      check("t1_top0", 32'(top0), 0);
      check("t1_udf", 32'(udf0), 0);

      // T2: underflow, clear, and set-beats-clear
      cyc(0, 1, 0, 0, '0);
      check("t2_udf", 32'(udf0), 1);
      check("t2_cnt", 32'(cnt0), 0);
      cyc(0, 0, 0, 1, '0);
      check("t2_clr", 32'(udf0), 0);
      cyc(0, 1, 0, 1, '0);
      check("t2_set_wins", 32'(udf0), 1);
      cyc(0, 0, 0, 1, '0);

      // T3/T4: push past full in reject and wrap modes
      for (int i = 1; i <= 9; i++) cyc(1, 0, 0, 0, pc_t'(i));
      check("t3_full", 32'(ful0), 1);
      check("t3_cnt", 32'(cnt0), 8);
      check("t3_ovf", 32'(ovf0), 1);
      check("t3_top", 32'(top0), 8);
      check("t3_w_top", 32'(top1), 9);
      for (int i = 8; i >= 1; i--) begin
         check("t3_pop", 32'(top0), 32'(i));
         check("t3_w_pop", 32'(top1), 32'(i + 1));
         cyc(0, 1, 0, 0, '0);
      end
      check("t3_empty", 32'(emp0), 1);
      cyc(0, 0, 0, 1, '0);
      for (int i = 1; i <= 10; i++) cyc(1, 0, 0, 0, pc_t'(i));
      check("t4_cnt", 32'(cnt1), 8);
      check("t4_ovf", 32'(ovf1), 1);
      check("t4_top", 32'(top1), 10);
      for (int i = 10; i >= 3; i--) begin
         check("t4_pop", 32'(top1), 32'(i));
         cyc(0, 1, 0, 0, '0);
      end
      check("t4_empty", 32'(emp1), 1);
      cyc(0, 0, 0, 1, '0);

      // T5: replace-top, including on a full stack and on an empty one
      cyc(1, 0, 0, 0, 18'h11111);
      cyc(1, 0, 0, 0, 18'h22222);
      cyc(1, 1, 0, 0, 18'h33333);
      check("t5_cnt", 32'(cnt0), 2);
      check("t5_top", 32'(top0), 32'h33333);
      cyc(0, 1, 0, 0, '0);
      check("t5_under", 32'(top0), 32'h11111);
      cyc(0, 1, 0, 0, '0);
      cyc(1, 1, 0, 0, 18'h0AAAA);
      check("t5_e_cnt", 32'(cnt0), 1);
      check("t5_e_top", 32'(top0), 32'h0AAAA);
      check("t5_e_udf", 32'(udf0), 0);
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, pc_t'(18'h100 + i));
      cyc(1, 1, 0, 0, 18'h2BEEF);
      check("t5_f_top", 32'(top0), 32'h2BEEF);
      check("t5_f_ovf", 32'(ovf0), 0);
      check("t5_f_cnt", 32'(cnt0), 8);

      // T6: flush (push ignored), then asynchronous reset mid-cycle
      cyc(1, 0, 1, 0, 18'h3CCCC);
      check("t6_cnt", 32'(cnt0), 0);
      check("t6_empty", 32'(emp0), 1);
      check("t6_top", 32'(top0), 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, pc_t'(18'h200 + i));
      check("t6_pre", 32'(cnt0), 3);
      rst_n = 1'b0;
      #1;
      check("t6_rst_cnt", 32'(cnt0), 0);
      check("t6_rst_top", 32'(top0), 0);
      check("t6_rst_w_cnt", 32'(cnt1), 0);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      cyc(1, 0, 0, 0, 18'h12345);
      check("t6_post_cnt", 32'(cnt0), 1);
      check("t6_post_top", 32'(top0), 32'h12345);
      cyc(0, 0, 0, 0, '0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
